// File: rtl/sram_emulator_if.sv
// Pin-level control bundle between sram_controller and sram_emulator.
// The 64-bit data bus is a separate inout port so tristate resolution stays on a plain net.
interface sram_emulator_if;
  logic        CE_N;
  logic        OE_N;
  logic        WE_N;
  logic        LB_N;
  logic        UB_N;
  logic [19:0] addr;
  logic        proto_err;

  modport master (
    output CE_N, OE_N, WE_N, LB_N, UB_N, addr,
    input  proto_err
  );

  modport slave (
    input  CE_N, OE_N, WE_N, LB_N, UB_N, addr,
    output proto_err
  );
endinterface

// File: rtl/sram_emulator.sv
// Clocked 64-bit async SRAM emulator with programmable access latency.
// Optional protocol checker built when SRAM_EMU_PROTOCOL_CHECK_EN is defined.
module sram_emulator #(
  parameter int rw_cycles  = 3,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic          clk,
  input  logic          rst,
  sram_emulator_if.slave bus,
  inout  wire  [63:0]   data
);

  localparam int CW = $clog2(rw_cycles + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_WAIT,
    WR_DONE
  } state_t;

  logic [63:0] mem [2**DEPTH_LOG2];

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [19:0]           a_q, a_d;
  logic [63:0]           rd_q, rd_d;
  logic                  wr_dec, rd_dec, same, last;
  logic                  start_rd, start_wr, we;
  logic [DEPTH_LOG2-1:0] w_idx, a_idx, n_idx;
  logic [63:0]           wdata;
  logic                  drv;

  always_comb begin
    wr_dec   = !bus.CE_N && !bus.WE_N;
    rd_dec   = !bus.CE_N && bus.WE_N && !bus.OE_N;
    same     = (bus.addr == a_q);
    last     = (int'(cnt_q) + 1) >= rw_cycles;
    a_idx    = a_q[DEPTH_LOG2-1:0];
    n_idx    = bus.addr[DEPTH_LOG2-1:0];
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    rd_d     = rd_q;
    we       = 1'b0;
    w_idx    = a_idx;
    start_rd = 1'b0;
    start_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_dec)      start_wr = 1'b1;
        else if (rd_dec) start_rd = 1'b1;
      end
      RD_WAIT, RD_DRIVE: begin
        if (wr_dec)                 start_wr = 1'b1;
        else if (!rd_dec)           state_d  = IDLE;
        else if (!same)             start_rd = 1'b1;
        else if (state_q == RD_WAIT) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            rd_d    = mem[a_idx];
            state_d = RD_DRIVE;
          end
        end
      end
      WR_WAIT: begin
        if (!wr_dec) state_d = IDLE;
        else begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            we      = 1'b1;
            state_d = WR_DONE;
          end
        end
      end
      WR_DONE: if (!wr_dec) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // single-cycle latency completes in the same edge that starts the access
    if (start_rd) begin
      a_d   = bus.addr;
      cnt_d = CW'(1);
      if (rw_cycles == 1) begin
        rd_d    = mem[n_idx];
        state_d = RD_DRIVE;
      end else begin
        state_d = RD_WAIT;
      end
    end
    if (start_wr) begin
      a_d   = bus.addr;
      cnt_d = CW'(1);
      if (rw_cycles == 1) begin
        we      = 1'b1;
        w_idx   = n_idx;
        state_d = WR_DONE;
      end else begin
        state_d = WR_WAIT;
      end
    end
    wdata = {bus.UB_N ? mem[w_idx][63:32] : data[63:32],
             bus.LB_N ? mem[w_idx][31:0]  : data[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[w_idx] <= wdata;
  end

  assign drv = (state_q == RD_DRIVE) && !bus.CE_N
            && !bus.OE_N && bus.WE_N;

  assign data[31:0]  = (drv && !bus.LB_N) ? rd_q[31:0]  : 32'bz;
  assign data[63:32] = (drv && !bus.UB_N) ? rd_q[63:32] : 32'bz;

`ifdef SRAM_EMU_PROTOCOL_CHECK_EN
  logic perr_q, perr_d, perr_hit;

  always_comb begin
    perr_hit = (!bus.CE_N && !bus.OE_N && !bus.WE_N)
            || (state_q == WR_WAIT && (!wr_dec || !same))
            || ((wr_dec || rd_dec) && bus.LB_N && bus.UB_N);
    perr_d   = perr_q || perr_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign bus.proto_err = perr_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && perr_hit)
      $error("sram_emulator: protocol violation addr=%h", bus.addr);
  end
`endif
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_emulator.sv
// Directed plus randomized bench for sram_emulator against a word/lane memory model.
// Released bus lanes read as 0 through the pulled-down data net.
module tb_sram_emulator;

  localparam int RW    = 3;
  localparam int DEPTH = 1024;
`ifdef SRAM_EMU_PROTOCOL_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        tb_en;
  logic [63:0] tb_dat;
  tri0  [63:0] data;

  int checks   = 0;
  int failures = 0;

  logic [63:0] model [DEPTH];

  sram_emulator_if bus ();

  assign data = tb_en ? tb_dat : 64'bz;

  sram_emulator #(.rw_cycles(RW), .DEPTH_LOG2(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.CE_N = 1'b1;
    bus.OE_N = 1'b1;
    bus.WE_N = 1'b1;
    bus.LB_N = 1'b0;
    bus.UB_N = 1'b0;
    tb_en    = 1'b0;
  endtask

  // Only the bus value present at edge E(RW-1) may land in memory.
  task automatic do_write(input logic [19:0] a, input logic [63:0] v,
                          input logic lb, input logic ub, input int hold);
    int idx;
    bus.CE_N = 1'b0;
    bus.WE_N = 1'b0;
    bus.OE_N = 1'b1;
    bus.LB_N = lb;
    bus.UB_N = ub;
    bus.addr = a;
    tb_en    = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tb_dat = (k == RW - 1) ? v : ~v;
      tick();
    end
    idle_bus();
    tick();
    idx = int'(a) % DEPTH;
    if (!lb) model[idx][31:0]  = v[31:0];
    if (!ub) model[idx][63:32] = v[63:32];
  endtask

  task automatic do_read(input string tag, input logic [19:0] a,
                         input logic lb, input logic ub,
                         output logic [63:0] obs);
    logic [63:0] m, exp;
    m   = model[int'(a) % DEPTH];
    exp = {ub ? 32'h0 : m[63:32], lb ? 32'h0 : m[31:0]};
    bus.CE_N = 1'b0;
    bus.OE_N = 1'b0;
    bus.WE_N = 1'b1;
    bus.LB_N = lb;
    bus.UB_N = ub;
    bus.addr = a;
    tb_en    = 1'b0;
    for (int k = 0; k < RW - 1; k++) begin
      tick();
      chk({tag, "_early"}, data, 64'h0);
    end
    tick();
    obs = data;
    chk({tag, "_data"}, obs, exp);
    bus.OE_N = 1'b1;
    #1;
    chk({tag, "_release"}, data, 64'h0);
    idle_bus();
    tick();
  endtask

  initial begin
    logic [63:0] obs, v;
    logic [19:0] a;
    logic        lb, ub;
    for (int i = 0; i < DEPTH; i++) model[i] = 64'h0;
    rst    = 1'b1;
    tb_dat = 64'h0;
    bus.addr = 20'h0;
    idle_bus();
    tick();
    tick();
    rst = 1'b0;
    chk("reset_proto_err", {63'h0, bus.proto_err}, 64'h0);
    chk("reset_bus_z", data, 64'h0);

    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom} | 64'h00000001_00000001;
      do_write(20'(i), v, 1'b0, 1'b0, RW);
    end

    do_write(20'h00005, 64'h0123456789ABCDEF, 1'b0, 1'b0, 6);
    do_read("rd5", 20'h00005, 1'b0, 1'b0, obs);
    chk("wr5_value", obs, 64'h0123456789ABCDEF);

    do_write(20'h00007, 64'h0, 1'b0, 1'b0, RW);
    do_write(20'h00007, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b1, RW);
    do_read("rd7", 20'h00007, 1'b0, 1'b0, obs);
    chk("lane_merge", obs, 64'h00000000_FFFFFFFF);
    do_read("rd7_lbn", 20'h00007, 1'b1, 1'b0, obs);
    chk("lb_off_low_z", {32'h0, obs[31:0]}, 64'h0);

    bus.CE_N = 1'b0;
    bus.OE_N = 1'b0;
    bus.WE_N = 1'b1;
    bus.addr = 20'h00003;
    tick();
    bus.addr = 20'h00004;
    tick();
    tick();
    chk("addr_chg_no_drive", data, 64'h0);
    tick();
    chk("addr_chg_new_data", data, model[4]);
    idle_bus();
    tick();

    do_write(20'h00009, 64'hA5A5_0000_5A5A_1111, 1'b0, 1'b0, RW);
    bus.CE_N = 1'b0;
    bus.WE_N = 1'b0;
    bus.OE_N = 1'b1;
    bus.addr = 20'h00009;
    tb_en    = 1'b1;
    tb_dat   = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_bus();
    tick();
    chk("rst_mid_bus_z", data, 64'h0);
    do_read("rd9", 20'h00009, 1'b0, 1'b0, obs);
    chk("rst_no_commit", obs, 64'hA5A5_0000_5A5A_1111);

    do_write(20'h00405, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0, RW);
    do_read("alias5", 20'h00005, 1'b0, 1'b0, obs);
    chk("alias_value", obs, 64'h1357_9BDF_2468_ACE0);
    do_read("alias805", 20'h00805, 1'b0, 1'b0, obs);

    for (int i = 0; i < 60; i++) begin
      a  = 20'($urandom) & 20'hFFC0F;
      lb = 1'($urandom_range(0, 1));
      ub = 1'($urandom_range(0, 1));
      if (PCHK && lb && ub) lb = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        v = {$urandom, $urandom} | 64'h00000001_00000001;
        do_write(a, v, lb, ub, RW + int'($urandom_range(0, 3)));
      end else begin
        do_read("rnd", a, lb, ub, obs);
      end
    end

    bus.CE_N = 1'b0;
    bus.OE_N = 1'b0;
    bus.WE_N = 1'b0;
    bus.addr = 20'h00014;
    tick();
    chk("proto_set", {63'h0, bus.proto_err}, {63'h0, PCHK});
    idle_bus();
    tick();
    tick();
    chk("proto_sticky", {63'h0, bus.proto_err}, {63'h0, PCHK});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("proto_rst_clear", {63'h0, bus.proto_err}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
